alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the 32-bit ALU (ports A, B, ALUctl[3:0]).
- Accepts decoded instruction fields plus register-file operands and forms the ALU control code and the B operand (register or extended immediate).
- Registers A, B and ALUctl behind a valid/ready handshake with a 2-entry skid buffer, so the ALU input is stable and back-pressure does not drop work.

Parameters:
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds valid op.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  6  instruction opcode.
- in_funct  in  6  R-type funct field.
- in_rs_data  in  32  rs register value.
- in_rt_data  in  32  rt register value.
- in_imm  in  16  immediate field.
- A  out  32  ALU operand A, registered.
- B  out  32  ALU operand B, registered.
- ALUctl  out  4  ALU control, registered.
- out_illegal  out  1  issued op was undecodable.
- out_valid  out  1  A/B/ALUctl valid.
- out_ready  in  1  downstream consumes this cycle.
- issued_count  out  CNT_W  ops handed downstream (out_valid and out_ready).

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0, skid_valid=0.
  - A=0, B=0, ALUctl=4'b0000, out_illegal=0, issued_count=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst falls.
  - Reset mid-transfer discards both entries with no output.
- Decode (combinational, in sub-module):
  - R-type opcode 000000. B=rt. Funct mapping:
    - 100000 add -> 0010
    - 100010 sub -> 0110
    - 100100 and -> 0000
    - 100101 or -> 0001
    - 101010 slt -> 0111
    - 100111 nor -> 1100
  - I-type, B = sign-extended imm:
    - 001000 addi -> 0010
    - 001010 slti -> 0111
    - 100011 lw -> 0010
    - 101011 sw -> 0010
  - I-type, B = zero-extended imm:
    - 001100 andi -> 0000
    - 001101 ori -> 0001
  - 000100 beq -> 0110, B=rt.
  - A = rs in all cases.
  - Any other opcode or funct: ALUctl=0000, B=rt, illegal=1. The op still issues and is never dropped.
- Handshake:
  - A transfer occurs when valid and ready are both high in the same cycle.
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Latency: an op accepted in cycle N appears on A/B/ALUctl/out_valid in cycle N+1.
  - Throughput: 1 op/cycle while out_ready=1.
- Skid buffer states (main entry, skid entry):
  - EMPTY: accept -> main loads, goes to ONE.
  - ONE:
    - out_ready=1 with accept -> main reloads, stays ONE.
    - out_ready=1 without accept -> EMPTY.
    - out_ready=0 with accept -> skid loads, goes to FULL.
  - FULL:
    - in_ready=0.
    - out_ready=1 -> main <= skid, goes to ONE. in_ready returns to 1 the next cycle.
  - Order is preserved. Outputs hold stable while out_valid=1 and out_ready=0.
- Counter: issued_count increments on each output transfer and wraps from 2^CNT_W-1 to 0.
- out_ready with out_valid=0 has no effect.

Decomposition:
- Package alu_pkg:
  - ALUctl localparams: AND, OR, ADD, SUB, SLT, NOR.
  - Opcode and funct localparams.
  - 32-bit word width constant.
- Sub-module alu_ctl_decode:
  - Purely combinational.
  - Inputs: opcode, funct, imm, rt.
  - Outputs: ALUctl, B_sel value, illegal.
- Top level holds the skid buffer, handshake and counter.

Test Plan:
- R-type sweep with out_ready=1: rs=32'h55555555, rt=32'haaaaaaaa, one op per cycle through add, sub, and, or, slt, nor -> next cycle each, ALUctl = 0010, 0110, 0000, 0001, 0111, 1100. B=32'haaaaaaaa. No bubbles. issued_count=6.
- Immediate extension:
  - addi imm=16'hFFFC -> B=32'hFFFFFFFC, ALUctl=0010.
  - ori imm=16'h8001 -> B=32'h00008001, ALUctl=0001.
- Back-pressure: hold out_ready=0 and present 3 ops.
  - Ops 1–2 accepted; in_ready=0 in the cycle after the second accept.
  - Op 3 is held upstream.
  - Release out_ready -> ops emerge in order 1, 2, 3 with no loss or duplication.
- Illegal op: opcode 111111 -> out_illegal=1, ALUctl=0000, B=rt. The following legal op has out_illegal=0.
- Reset mid-operation: assert rst while FULL -> next cycle out_valid=0, issued_count=0, A=B=0. in_ready=1 the cycle after rst falls.
- Counter wrap: with CNT_W=4, issue 17 ops -> issued_count=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: ALU control codes,
// opcode/funct encodings, the issue entry record and skid-buffer occupancy.
package alu_pkg;

  localparam int WORD_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [3:0]        ctl;
    logic              illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of opcode/funct into ALU control and the B operand.
// Undecodable ops still produce a well-defined entry (AND, B=rt) flagged illegal.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [WORD_W-1:0] rt,
  output logic [3:0]        alu_ctl,
  output logic [WORD_W-1:0] b_sel,
  output logic              illegal
);

  logic [WORD_W-1:0] imm_sext;
  logic [WORD_W-1:0] imm_zext;

  assign imm_sext = {{(WORD_W-16){imm[15]}}, imm};
  assign imm_zext = {{(WORD_W-16){1'b0}}, imm};

  // Opcode/funct lookup; defaults cover every undecodable combination.
  always_comb begin
    alu_ctl = ALU_AND;
    b_sel   = rt;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          FN_NOR:  alu_ctl = ALU_NOR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        alu_ctl = ALU_ADD;
        b_sel   = imm_sext;
      end
      OP_SLTI: begin
        alu_ctl = ALU_SLT;
        b_sel   = imm_sext;
      end
      OP_ANDI: begin
        alu_ctl = ALU_AND;
        b_sel   = imm_zext;
      end
      OP_ORI: begin
        alu_ctl = ALU_OR;
        b_sel   = imm_zext;
      end
      OP_BEQ:  alu_ctl = ALU_SUB;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decodes the op, registers A/B/ALUctl behind
// a valid/ready handshake with a two-entry skid buffer, and counts issued ops.
//
// state    | meaning
// SK_EMPTY | nothing held, out_valid=0
// SK_ONE   | main entry drives the ALU, skid empty
// SK_FULL  | main entry stalled, skid holds the next op, in_ready=0
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [WORD_W-1:0] in_rs_data,
  input  logic [WORD_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  output logic [WORD_W-1:0] A,
  output logic [WORD_W-1:0] B,
  output logic [3:0]        ALUctl,
  output logic              out_illegal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  issued_count
);

  skid_state_e  state, state_nxt;
  issue_entry_t main_q, skid_q, dec_entry;
  logic [3:0]        dec_ctl;
  logic [WORD_W-1:0] dec_b;
  logic              dec_ill;
  logic              acc, pop;
  logic              load_main, main_from_skid, load_skid;

  alu_ctl_decode u_dec (
    .opcode  (in_opcode),
    .funct   (in_funct),
    .imm     (in_imm),
    .rt      (in_rt_data),
    .alu_ctl (dec_ctl),
    .b_sel   (dec_b),
    .illegal (dec_ill)
  );

  assign dec_entry = {in_rs_data, dec_b, dec_ctl, dec_ill};

  // in_ready depends only on held state (and reset), never on out_ready.
  assign in_ready  = (state != SK_FULL) && !rst;
  assign out_valid = (state != SK_EMPTY);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy transitions and which entry loads from where.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      SK_EMPTY: begin
        if (acc) begin
          load_main = 1'b1;
          state_nxt = SK_ONE;
        end
      end
      SK_ONE: begin
        if (pop && acc) begin
          load_main = 1'b1;
        end else if (pop) begin
          state_nxt = SK_EMPTY;
        end else if (acc) begin
          load_skid = 1'b1;
          state_nxt = SK_FULL;
        end
      end
      SK_FULL: begin
        if (pop) begin
          main_from_skid = 1'b1;
          state_nxt      = SK_ONE;
        end
      end
      default: state_nxt = SK_EMPTY;
    endcase
  end

  // State, entry storage and issued-op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SK_EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      issued_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_q <= dec_entry;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_entry;
      end
      if (pop) begin
        issued_count <= issued_count + CNT_W'(1);
      end
    end
  end

  assign A           = main_q.a;
  assign B           = main_q.b;
  assign ALUctl      = main_q.ctl;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_alu_issue_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_opcode;
  logic [5:0]    in_funct;
  logic [31:0]   in_rs_data;
  logic [31:0]   in_rt_data;
  logic [15:0]   in_imm;
  logic [31:0]   A;
  logic [31:0]   B;
  logic [3:0]    ALUctl;
  logic          out_illegal;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] issued_count;

  alu_issue_stage #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_funct     (in_funct),
    .in_rs_data   (in_rs_data),
    .in_rt_data   (in_rt_data),
    .in_imm       (in_imm),
    .A            (A),
    .B            (B),
    .ALUctl       (ALUctl),
    .out_illegal  (out_illegal),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic        ill;
  } exp_t;

  exp_t          q[$];
  logic [CW-1:0] mcnt;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode table written straight from the instruction list.
  function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [15:0] imm);
    exp_t e;
    int   simm;
    simm  = int'($signed(imm));
    e.a   = rs;
    e.b   = rt;
    e.ctl = 4'b0000;
    e.ill = 1'b0;
    if (op == 6'b000000) begin
      if      (fn == 6'b100000) e.ctl = 4'b0010;
      else if (fn == 6'b100010) e.ctl = 4'b0110;
      else if (fn == 6'b100100) e.ctl = 4'b0000;
      else if (fn == 6'b100101) e.ctl = 4'b0001;
      else if (fn == 6'b101010) e.ctl = 4'b0111;
      else if (fn == 6'b100111) e.ctl = 4'b1100;
      else e.ill = 1'b1;
    end else if (op == 6'b001000 || op == 6'b100011 || op == 6'b101011) begin
      e.ctl = 4'b0010; e.b = 32'(simm);
    end else if (op == 6'b001010) begin
      e.ctl = 4'b0111; e.b = 32'(simm);
    end else if (op == 6'b001100) begin
      e.ctl = 4'b0000; e.b = 32'(imm);
    end else if (op == 6'b001101) begin
      e.ctl = 4'b0001; e.b = 32'(imm);
    end else if (op == 6'b000100) begin
      e.ctl = 4'b0110;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // One clock of traffic: drive, compare against the model, advance model and clock.
  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [15:0] imm, input logic ordy);
    logic acc, pop;
    in_valid   = v;
    in_opcode  = op;
    in_funct   = fn;
    in_rs_data = rs;
    in_rt_data = rt;
    in_imm     = imm;
    out_ready  = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("A", A, q[0].a);
      chk("B", B, q[0].b);
      chk("ALUctl", 32'(ALUctl), 32'(q[0].ctl));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
    chk("issued_count", 32'(issued_count), 32'(mcnt));
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    if (pop) begin
      void'(q.pop_front());
      mcnt = mcnt + 1'b1;
    end
    if (acc) q.push_back(ref_decode(op, fn, rs, rt, imm));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0, ordy);
  endtask

  logic [5:0] functs[6];
  logic [5:0] legal_ops[8];

  initial begin
    functs    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    legal_ops = '{6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011,
                  6'b001100, 6'b001101, 6'b000100};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct = '0; in_rs_data = '0; in_rt_data = '0; in_imm = '0;
    mcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(issued_count), 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_ALUctl", 32'(ALUctl), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // R-type sweep, one op per cycle.
    for (int i = 0; i < 6; i++) step(1'b1, 6'b000000, functs[i], 32'h55555555, 32'haaaaaaaa, 16'h0, 1'b1);
    idle(1'b1);
    chk("sweep_count", 32'(issued_count), 32'd6);

    // Immediate extension.
    step(1'b1, 6'b001000, 6'h00, 32'h00000010, 32'h12345678, 16'hFFFC, 1'b1);
    chk("addi_B", B, 32'hFFFFFFFC);
    chk("addi_ctl", 32'(ALUctl), 32'h2);
    step(1'b1, 6'b001101, 6'h00, 32'h00000020, 32'h12345678, 16'h8001, 1'b1);
    chk("ori_B", B, 32'h00008001);
    chk("ori_ctl", 32'(ALUctl), 32'h1);
    idle(1'b1);

    // Back-pressure: three ops with out_ready low, then release.
    step(1'b1, 6'b000000, 6'b100000, 32'd1, 32'd11, 16'h0, 1'b0);
    chk("bp_A1", A, 32'd1);
    step(1'b1, 6'b000000, 6'b100010, 32'd2, 32'd12, 16'h0, 1'b0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 6'b000000, 6'b100100, 32'd3, 32'd13, 16'h0, 1'b0);
    step(1'b1, 6'b000000, 6'b100100, 32'd3, 32'd13, 16'h0, 1'b0);
    chk("bp_hold_A1", A, 32'd1);
    step(1'b1, 6'b000000, 6'b100100, 32'd3, 32'd13, 16'h0, 1'b1);
    chk("bp_A2", A, 32'd2);
    step(1'b1, 6'b000000, 6'b100100, 32'd3, 32'd13, 16'h0, 1'b1);
    chk("bp_A3", A, 32'd3);
    idle(1'b1);
    idle(1'b1);

    // Illegal opcode followed by a legal op.
    step(1'b1, 6'b111111, 6'b100000, 32'hCAFE0000, 32'hDEADBEEF, 16'h1234, 1'b1);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_ctl", 32'(ALUctl), 32'd0);
    chk("ill_B", B, 32'hDEADBEEF);
    step(1'b1, 6'b000000, 6'b100101, 32'h1, 32'h2, 16'h0, 1'b1);
    chk("legal_after_ill", 32'(out_illegal), 32'd0);
    idle(1'b1);

    // Reset while the skid buffer is full.
    step(1'b1, 6'b000000, 6'b100000, 32'h77, 32'h88, 16'h0, 1'b0);
    step(1'b1, 6'b000000, 6'b100010, 32'h99, 32'haa, 16'h0, 1'b0);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    q.delete();
    mcnt = '0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(issued_count), 32'd0);
    chk("midrst_A", A, 32'd0);
    chk("midrst_B", B, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);

    // Counter wrap with a 4-bit counter.
    for (int i = 0; i < 17; i++) step(1'b1, 6'b001000, 6'h00, 32'(i), 32'h0, 16'(i), 1'b1);
    idle(1'b1);
    chk("wrap_count", 32'(issued_count), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
      step(1'($urandom), op, fn, $urandom, $urandom, 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
